// File: rtl/fir_sample_feeder_if.sv
// fir_sample_feeder_if: sample-source and FIRfilter-side signals of the sample feeder
interface fir_sample_feeder_if #(
    parameter int WIDTH  = 16,
    parameter int LENGHT = 100,
    parameter int DEPTH  = 8
);
    localparam int OUTPUT_WIDTH = $clog2(LENGHT) + 2 * WIDTH;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]        s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [WIDTH-1:0]        fir_input;
    logic                    fir_input_valid;
    logic                    fir_ready_for_input;
    logic [OUTPUT_WIDTH-1:0] fir_output;
    logic                    fir_output_valid;
    logic [OUTPUT_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic [CW-1:0]           fill_level;
    logic                    busy;
    logic                    timeout_err;

    modport master (
        input  s_data, s_valid, fir_ready_for_input, fir_output, fir_output_valid,
        output s_ready, fir_input, fir_input_valid, r_data, r_valid, fill_level, busy, timeout_err
    );

    modport slave (
        output s_data, s_valid, fir_ready_for_input, fir_output, fir_output_valid,
        input  s_ready, fir_input, fir_input_valid, r_data, r_valid, fill_level, busy, timeout_err
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO-buffered, one-in-flight sample feeder for FIRfilter with result watchdog
module fir_sample_feeder #(
    parameter int WIDTH   = 16,
    parameter int LENGHT  = 100,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 512
) (
    input logic                  clk,
    input logic                  rst,
    fir_sample_feeder_if.master  bus
);
    localparam int OUTPUT_WIDTH = $clog2(LENGHT) + 2 * WIDTH;
    localparam int AW           = $clog2(DEPTH);
    localparam int CW           = AW + 1;
    localparam int TW           = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_avail;
    logic [1:0]              r_state;
    logic [TW-1:0]           r_timer;
    logic [WIDTH-1:0]        r_fir_input;
    logic                    r_fir_input_valid;
    logic [OUTPUT_WIDTH-1:0] r_result;
    logic                    r_result_valid;
    logic                    r_timeout_err;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_expire;

    // r_avail is the one-cycle-late view of occupancy, so a fresh write reaches the FSM a cycle later
    assign w_push   = bus.s_valid && bus.s_ready;
    assign w_pop    = (r_state == IDLE) && r_avail && (r_count != '0);
    assign w_expire = r_timer == TW'(TIMEOUT - 1);

    assign bus.s_ready         = r_count < CW'(DEPTH);
    assign bus.fill_level      = r_count;
    assign bus.busy            = (r_state != IDLE) || (r_count != '0);
    assign bus.fir_input       = r_fir_input;
    assign bus.fir_input_valid = r_fir_input_valid;
    assign bus.r_data          = r_result;
    assign bus.r_valid         = r_result_valid;
    assign bus.timeout_err     = r_timeout_err;

    // Sample storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.s_data;
    end

    // FIFO pointers, occupancy and the delayed not-empty flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_avail  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_avail <= r_count != '0;
        end
    end

    // Sequencer: IDLE pops a sample, SEND holds the handshake, WAIT collects the result or times out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= IDLE;
            r_timer           <= '0;
            r_fir_input       <= '0;
            r_fir_input_valid <= 1'b0;
            r_result          <= '0;
            r_result_valid    <= 1'b0;
            r_timeout_err     <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_fir_input       <= r_mem[r_rd_ptr];
                    r_fir_input_valid <= 1'b1;
                    r_state           <= SEND;
                end
                SEND: if (bus.fir_ready_for_input) begin
                    r_fir_input_valid <= 1'b0;
                    r_timer           <= '0;
                    r_state           <= WAIT;
                end
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.fir_output_valid) begin
                        r_result       <= bus.fir_output;
                        r_result_valid <= 1'b1;
                        r_state        <= IDLE;
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed scenario tests for the FIR sample feeder with a stubbed filter
module tb_fir_sample_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    fir_sample_feeder_if #(.WIDTH(16), .LENGHT(100), .DEPTH(8)) bus ();

    fir_sample_feeder #(.WIDTH(16), .LENGHT(100), .DEPTH(8), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        bus.fir_ready_for_input = 1'b0;
        bus.fir_output = '0;
        bus.fir_output_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        n_chk++; if (bus.fir_input_valid !== 1'b0 || bus.fir_input !== 16'h0) $display("FAIL rst_fir_in got v=%b d=%h exp v=0 d=0000", bus.fir_input_valid, bus.fir_input); else n_pass++;
        n_chk++; if (bus.r_valid !== 1'b0 || bus.r_data !== 39'h0) $display("FAIL rst_result got v=%b d=%h exp v=0 d=0", bus.r_valid, bus.r_data); else n_pass++;
        n_chk++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0 || bus.fill_level !== 4'd0) $display("FAIL rst_status got err=%b busy=%b fill=%0d exp 0 0 0", bus.timeout_err, bus.busy, bus.fill_level); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if (bus.s_ready !== 1'b1) $display("FAIL rst_s_ready got %b exp 1", bus.s_ready); else n_pass++;
    endtask

    task automatic test_single();
        bus.fir_ready_for_input = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 16'h0003;
        tick();
        bus.s_valid = 1'b0;
        n_chk++; if (bus.fill_level !== 4'd1) $display("FAIL t1_fill got %0d exp 1", bus.fill_level); else n_pass++;
        tick();
        n_chk++; if (bus.fir_input_valid !== 1'b0) $display("FAIL t1_latency got valid=%b exp 0", bus.fir_input_valid); else n_pass++;
        tick();
        n_chk++; if (bus.fir_input_valid !== 1'b1 || bus.fir_input !== 16'h0003) $display("FAIL t1_present got v=%b d=%h exp v=1 d=0003", bus.fir_input_valid, bus.fir_input); else n_pass++;
        tick();
        n_chk++; if (bus.fir_input_valid !== 1'b0) $display("FAIL t1_one_valid got %b exp 0", bus.fir_input_valid); else n_pass++;
        bus.fir_ready_for_input = 1'b0;
        bus.fir_output = 39'h12345;
        repeat (4) tick();
        n_chk++; if (bus.r_valid !== 1'b0) $display("FAIL t1_early_r_valid got %b exp 0", bus.r_valid); else n_pass++;
        bus.fir_output_valid = 1'b1;
        tick();
        bus.fir_output_valid = 1'b0;
        n_chk++; if (bus.r_valid !== 1'b1 || bus.r_data !== 39'h12345) $display("FAIL t1_result got v=%b d=%h exp v=1 d=12345", bus.r_valid, bus.r_data); else n_pass++;
        tick();
        n_chk++; if (bus.r_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL t1_after got r_valid=%b busy=%b exp 0 0", bus.r_valid, bus.busy); else n_pass++;
    endtask

    task automatic test_fill_and_stall();
        int bad = 0;
        for (int i = 0; i < 9; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = 16'h0100 + 16'(i);
            tick();
        end
        bus.s_data = 16'h0109;
        n_chk++; if (bus.fill_level !== 4'd8 || bus.s_ready !== 1'b0) $display("FAIL t2_full got fill=%0d s_ready=%b exp 8 0", bus.fill_level, bus.s_ready); else n_pass++;
        n_chk++; if (bus.fir_input_valid !== 1'b1 || bus.fir_input !== 16'h0100) $display("FAIL t2_first_send got v=%b d=%h exp v=1 d=0100", bus.fir_input_valid, bus.fir_input); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.fir_input_valid !== 1'b1 || bus.fir_input !== 16'h0100 || bus.fill_level !== 4'd8) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL t3_hold got %0d unstable cycles exp 0", bad); else n_pass++;
        bus.fir_ready_for_input = 1'b1;
        tick();
        bus.fir_ready_for_input = 1'b0;
        n_chk++; if (bus.fir_input_valid !== 1'b0 || bus.fill_level !== 4'd8) $display("FAIL t2_transfer got v=%b fill=%0d exp v=0 fill=8", bus.fir_input_valid, bus.fill_level); else n_pass++;
        bus.fir_output = 39'h0ABC;
        bus.fir_output_valid = 1'b1;
        tick();
        bus.fir_output_valid = 1'b0;
        n_chk++; if (bus.r_valid !== 1'b1 || bus.r_data !== 39'h0ABC) $display("FAIL t2_result got v=%b d=%h exp v=1 d=abc", bus.r_valid, bus.r_data); else n_pass++;
        tick();
        n_chk++; if (bus.fir_input !== 16'h0101 || bus.fill_level !== 4'd7 || bus.s_ready !== 1'b1) $display("FAIL t2_next got d=%h fill=%0d s_ready=%b exp 0101 7 1", bus.fir_input, bus.fill_level, bus.s_ready); else n_pass++;
        tick();
        bus.s_valid = 1'b0;
        n_chk++; if (bus.fill_level !== 4'd8) $display("FAIL t2_tenth_push got fill=%0d exp 8", bus.fill_level); else n_pass++;
    endtask

    task automatic test_tie();
        bus.fir_ready_for_input = 1'b1;
        tick();
        bus.fir_ready_for_input = 1'b0;
        repeat (15) tick();
        n_chk++; if (bus.r_valid !== 1'b0 || bus.timeout_err !== 1'b0) $display("FAIL tie_pre got r_valid=%b err=%b exp 0 0", bus.r_valid, bus.timeout_err); else n_pass++;
        bus.fir_output = 39'h5555;
        bus.fir_output_valid = 1'b1;
        tick();
        bus.fir_output_valid = 1'b0;
        n_chk++; if (bus.r_valid !== 1'b1 || bus.r_data !== 39'h5555 || bus.timeout_err !== 1'b0) $display("FAIL tie_result got v=%b d=%h err=%b exp v=1 d=5555 err=0", bus.r_valid, bus.r_data, bus.timeout_err); else n_pass++;
        tick();
        n_chk++; if (bus.fir_input_valid !== 1'b1 || bus.fir_input !== 16'h0102) $display("FAIL tie_next got v=%b d=%h exp v=1 d=0102", bus.fir_input_valid, bus.fir_input); else n_pass++;
    endtask

    task automatic test_timeout();
        int seen = 0;
        bus.fir_ready_for_input = 1'b1;
        tick();
        bus.fir_ready_for_input = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.r_valid !== 1'b0) seen++;
        end
        n_chk++; if (bus.timeout_err !== 1'b0) $display("FAIL t4_early_err got %b exp 0 after 15 cycles", bus.timeout_err); else n_pass++;
        tick();
        if (bus.r_valid !== 1'b0) seen++;
        n_chk++; if (bus.timeout_err !== 1'b1) $display("FAIL t4_err got %b exp 1 after 16 cycles", bus.timeout_err); else n_pass++;
        n_chk++; if (seen != 0) $display("FAIL t4_no_r_valid got %0d pulses exp 0", seen); else n_pass++;
        bus.fir_output = 39'h7777;
        bus.fir_output_valid = 1'b1;
        tick();
        bus.fir_output_valid = 1'b0;
        n_chk++; if (bus.r_valid !== 1'b0 || bus.r_data !== 39'h5555) $display("FAIL t5_idle_pulse got v=%b d=%h exp v=0 d=5555", bus.r_valid, bus.r_data); else n_pass++;
        n_chk++; if (bus.fir_input_valid !== 1'b1 || bus.fir_input !== 16'h0103) $display("FAIL t4_next_sent got v=%b d=%h exp v=1 d=0103", bus.fir_input_valid, bus.fir_input); else n_pass++;
    endtask

    task automatic test_send_pulse();
        bus.fir_output = 39'h6666;
        bus.fir_output_valid = 1'b1;
        tick();
        bus.fir_output_valid = 1'b0;
        tick();
        n_chk++; if (bus.r_valid !== 1'b0 || bus.r_data !== 39'h5555 || bus.fir_input_valid !== 1'b1) $display("FAIL t5_send_pulse got v=%b d=%h in_v=%b exp v=0 d=5555 in_v=1", bus.r_valid, bus.r_data, bus.fir_input_valid); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bus.fir_ready_for_input = 1'b1;
        tick();
        bus.fir_ready_for_input = 1'b0;
        tick();
        n_chk++; if (bus.busy !== 1'b1 || bus.fill_level !== 4'd6) $display("FAIL t6_pre got busy=%b fill=%0d exp 1 6", bus.busy, bus.fill_level); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (bus.fill_level !== 4'd0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) $display("FAIL t6_async got fill=%0d busy=%b err=%b exp 0 0 0", bus.fill_level, bus.busy, bus.timeout_err); else n_pass++;
        n_chk++; if (bus.fir_input !== 16'h0 || bus.fir_input_valid !== 1'b0 || bus.r_data !== 39'h0 || bus.r_valid !== 1'b0) $display("FAIL t6_outputs got in=%h in_v=%b r=%h r_v=%b exp all 0", bus.fir_input, bus.fir_input_valid, bus.r_data, bus.r_valid); else n_pass++;
        tick();
        rst = 1'b1;
        bus.fir_output = 39'h9999;
        bus.fir_output_valid = 1'b1;
        tick();
        bus.fir_output_valid = 1'b0;
        n_chk++; if (bus.r_valid !== 1'b0 || bus.r_data !== 39'h0) $display("FAIL t6_late_result got v=%b d=%h exp v=0 d=0", bus.r_valid, bus.r_data); else n_pass++;
        tick();
        n_chk++; if (bus.fir_input_valid !== 1'b0 || bus.fill_level !== 4'd0 || bus.s_ready !== 1'b1) $display("FAIL t6_after got in_v=%b fill=%0d s_ready=%b exp 0 0 1", bus.fir_input_valid, bus.fill_level, bus.s_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_stall();
        test_tie();
        test_timeout();
        test_send_pulse();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion exp finish before 100000");
        $fatal(1, "watchdog");
    end
endmodule
